// File: rtl/universal_shift_seq_pkg.sv
// usrseq_pkg: mode codes and FSM state encoding shared by the universal shift sequencer
package usrseq_pkg;
    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_LOAD = 3'd1;
    localparam logic [2:0] MODE_INV  = 3'd2;
    localparam logic [2:0] MODE_SHR  = 3'd3;
    localparam logic [2:0] MODE_SHL  = 3'd4;
    localparam logic [2:0] MODE_ROR  = 3'd5;
    localparam logic [2:0] MODE_ROL  = 3'd6;
    localparam logic [2:0] MODE_LFSR = 3'd7;
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_RUN    = 1'b1;
endpackage

// File: rtl/universal_shift_seq_next.sv
// universal_reg_next: combinational next-value of the universal register for one step
module universal_reg_next
    import usrseq_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter logic [WIDTH-1:0] SEED  = 8'd1
) (
    input  logic [WIDTH-1:0] p,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] p_din,
    input  logic             s_right_din,
    input  logic             s_left_din,
    output logic [WIDTH-1:0] p_nxt
);
    logic [WIDTH-1:0] lfsr;
    // An all-zero state would lock the LFSR, so it is reseeded instead
    assign lfsr = (p == '0) ? SEED : ({1'b0, p[WIDTH-1:1]} ^ (p[0] ? TAPS : '0));
    always_comb begin
        p_nxt = (mode == MODE_LOAD) ? p_din :
                (mode == MODE_INV)  ? ~p :
                (mode == MODE_SHR)  ? {s_right_din, p[WIDTH-1:1]} :
                (mode == MODE_SHL)  ? {p[WIDTH-2:0], s_left_din} :
                (mode == MODE_ROR)  ? {p[0], p[WIDTH-1:1]} :
                (mode == MODE_ROL)  ? {p[WIDTH-2:0], p[WIDTH-1]} :
                (mode == MODE_LFSR) ? lfsr : p;
    end
endmodule

// File: rtl/universal_shift_seq.sv
// universal_shift_seq: universal register repeating a latched operation for a programmed step count
module universal_shift_seq
    import usrseq_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               CNT_W = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter logic [WIDTH-1:0] INIT  = '0,
    parameter logic [WIDTH-1:0] SEED  = 8'd1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] steps,
    input  logic [WIDTH-1:0] p_din,
    input  logic             s_right_din,
    input  logic             s_left_din,
    output logic [WIDTH-1:0] p_dout,
    output logic             s_left_dout,
    output logic             s_right_dout,
    output logic             busy,
    output logic             done
);
    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [2:0]       mode_q, mode_d;
    logic [WIDTH-1:0] p_q, p_d, p_nxt;
    logic             done_q, done_d;
    logic             idle, go, last;

    universal_reg_next #(.WIDTH(WIDTH), .TAPS(TAPS), .SEED(SEED)) u_next (
        .p           (p_q),
        .mode        (mode_q),
        .p_din       (p_din),
        .s_right_din (s_right_din),
        .s_left_din  (s_left_din),
        .p_nxt       (p_nxt)
    );

    assign idle = (state_q == ST_IDLE);
    assign go   = idle && start;
    assign last = !idle && (rem_q == CNT_W'(1));

    always_comb begin
        mode_d  = go ? mode : mode_q;
        rem_d   = go ? steps : idle ? rem_q : rem_q - CNT_W'(1);
        state_d = (go && steps != '0) ? ST_RUN : last ? ST_IDLE : state_q;
        p_d     = idle ? p_q : p_nxt;
        done_d  = (go && steps == '0) || last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            mode_q  <= MODE_HOLD;
            p_q     <= INIT;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            p_q     <= p_d;
            done_q  <= done_d;
        end
    end

    assign p_dout       = p_q;
    assign s_left_dout  = p_q[0];
    assign s_right_dout = p_q[WIDTH-1];
    assign busy         = (state_q == ST_RUN);
    assign done         = done_q;
endmodule

// File: tb/tb_universal_shift_seq.sv
// tb_universal_shift_seq: randomized scenario bench against an arithmetic reference model
module tb_universal_shift_seq;
    logic       clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic       s_right_din = 1'b0, s_left_din = 1'b0;
    logic [2:0] mode = 3'd0;
    logic [7:0] steps = 8'd0, p_din = 8'd0;
    logic [7:0] p_dout;
    logic       s_left_dout, s_right_dout, busy, done;
    int         tests = 0, fails = 0;
    logic [7:0] exp_p = 8'h00;
    bit         saw_zero;

    universal_shift_seq dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .steps(steps),
        .p_din(p_din), .s_right_din(s_right_din), .s_left_din(s_left_din),
        .p_dout(p_dout), .s_left_dout(s_left_dout), .s_right_dout(s_right_dout),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_step(input logic [7:0] p, input int m, input logic [7:0] d,
                                            input bit sr, input bit sl);
        int v, r;
        v = int'(p);
        case (m)
            1: r = int'(d);
            2: r = 255 - v;
            3: r = int'(sr) * 128 + v / 2;
            4: r = (v * 2) % 256 + int'(sl);
            5: r = (v % 2) * 128 + v / 2;
            6: r = (v * 2) % 256 + v / 128;
            7: r = (v == 0) ? 1 : ((v % 2 == 1) ? ((v / 2) ^ 'hB8) : v / 2);
            default: r = v;
        endcase
        return 8'(r);
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge inside the done cycle
    task automatic do_run(input int m, input int n, input logic [7:0] d, input bit sr, input bit sl, input bit rnd);
        start = 1'b1; mode = 3'(m); steps = 8'(n);
        @(negedge clk);
        start = 1'b0; mode = 3'($urandom); steps = 8'($urandom);
        saw_zero = 1'b0;
        for (int i = 0; i < n; i++) begin
            tests++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                fails++;
                $display("FAIL run_busy mode=%0d step=%0d: busy=%b done=%b, expected busy=1 done=0", m, i, busy, done);
            end
            start = 1'($urandom);
            if (rnd) begin
                p_din = 8'($urandom); s_right_din = 1'($urandom); s_left_din = 1'($urandom);
            end else begin
                p_din = d; s_right_din = sr; s_left_din = sl;
            end
            exp_p = ref_step(exp_p, m, p_din, s_right_din, s_left_din);
            @(negedge clk);
            if (p_dout == 8'h00) saw_zero = 1'b1;
            tests++;
            if (p_dout !== exp_p || s_left_dout !== exp_p[0] || s_right_dout !== exp_p[7]) begin
                fails++;
                $display("FAIL run_data mode=%0d step=%0d: p=%h sl=%b sr=%b, expected p=%h", m, i, p_dout, s_left_dout, s_right_dout, exp_p);
            end
        end
        start = 1'b0;
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || p_dout !== exp_p) begin
            fails++;
            $display("FAIL run_done mode=%0d steps=%0d: done=%b busy=%b p=%h, expected done=1 busy=0 p=%h", m, n, done, busy, p_dout, exp_p);
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        tests++;
        if (p_dout !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || s_left_dout !== 1'b0 || s_right_dout !== 1'b0) begin
            fails++;
            $display("FAIL reset: p=%h busy=%b done=%b, expected p=00 busy=0 done=0", p_dout, busy, done);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_p = 8'h00;
    endtask

    task automatic test_load_invert();
        do_run(1, 1, 8'hA5, 1'b0, 1'b0, 1'b0);
        tests++;
        if (p_dout !== 8'hA5) begin
            fails++; $display("FAIL load_a5: p=%h, expected a5", p_dout);
        end
        do_run(2, 3, 8'h00, 1'b0, 1'b0, 1'b0);
        tests++;
        if (p_dout !== 8'h5A) begin
            fails++; $display("FAIL invert3: p=%h, expected 5a", p_dout);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0) begin
            fails++; $display("FAIL done_single: done=%b, expected 0", done);
        end
    endtask

    task automatic test_shift();
        do_run(1, 1, 8'h00, 1'b0, 1'b0, 1'b0);
        do_run(4, 4, 8'h00, 1'b0, 1'b1, 1'b0);
        tests++;
        if (p_dout !== 8'h0F || s_left_dout !== 1'b1 || s_right_dout !== 1'b0) begin
            fails++; $display("FAIL shl4: p=%h sl=%b sr=%b, expected 0f 1 0", p_dout, s_left_dout, s_right_dout);
        end
        do_run(3, 4, 8'h00, 1'b0, 1'b1, 1'b0);
        tests++;
        if (p_dout !== 8'h00) begin
            fails++; $display("FAIL shr4: p=%h, expected 00", p_dout);
        end
    endtask

    task automatic test_rotate_zero();
        do_run(1, 1, 8'h81, 1'b0, 1'b0, 1'b0);
        do_run(5, 1, 8'h00, 1'b0, 1'b0, 1'b0);
        tests++;
        if (p_dout !== 8'hC0) begin
            fails++; $display("FAIL ror1: p=%h, expected c0", p_dout);
        end
        do_run(6, 8, 8'h00, 1'b0, 1'b0, 1'b0);
        tests++;
        if (p_dout !== 8'hC0) begin
            fails++; $display("FAIL rol8: p=%h, expected c0", p_dout);
        end
        do_run(1, 0, 8'hFF, 1'b0, 1'b0, 1'b0);
        tests++;
        if (p_dout !== 8'hC0 || busy !== 1'b0) begin
            fails++; $display("FAIL steps0: p=%h busy=%b, expected c0 0", p_dout, busy);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL steps0_after: done=%b busy=%b, expected 0 0", done, busy);
        end
    endtask

    task automatic test_lfsr();
        do_run(1, 1, 8'h00, 1'b0, 1'b0, 1'b0);
        do_run(7, 3, 8'h00, 1'b0, 1'b0, 1'b0);
        tests++;
        if (p_dout !== 8'h5C) begin
            fails++; $display("FAIL lfsr3: p=%h, expected 5c", p_dout);
        end
        do_run(1, 1, 8'h01, 1'b0, 1'b0, 1'b0);
        do_run(7, 255, 8'h00, 1'b0, 1'b0, 1'b0);
        tests++;
        if (p_dout !== 8'h01 || saw_zero !== 1'b0) begin
            fails++; $display("FAIL lfsr255: p=%h saw_zero=%b, expected 01 0", p_dout, saw_zero);
        end
    endtask

    task automatic test_abort();
        bit bad;
        @(negedge clk);
        start = 1'b1; mode = 3'd2; steps = 8'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if (p_dout !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL abort_rst: p=%h busy=%b done=%b, expected 00 0 0", p_dout, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_p = 8'h00;
        bad = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || p_dout !== 8'h00) bad = 1'b1;
        end
        tests++;
        if (bad !== 1'b0) begin
            fails++; $display("FAIL abort_quiet: stray activity after reset, p=%h busy=%b done=%b", p_dout, busy, done);
        end
    endtask

    task automatic test_back_to_back_random();
        for (int k = 0; k < 40; k++)
            do_run(int'($urandom_range(0, 7)), int'($urandom_range(0, 6)), 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_load_invert();
        test_shift();
        test_rotate_zero();
        test_lfsr();
        test_abort();
        test_back_to_back_random();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
